cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/cart_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_cart_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// ---------------------------------------------------------------------------
// cart_loader
// Receives a cartridge image from the host ioctl download channel, forwards
// every in-range byte to the machine core, pads the rest of the cart window
// with 8'hFF, then holds the CPU in reset for HOLD_CYCLES clocks before
// releasing it.
//
// Ports
//   clk            system clock (single domain)
//   reset_n        asynchronous active-low reset
//   ioctl_download host download session active
//   ioctl_index    session file index (stable while downloading)
//   ioctl_wr       one-cycle byte strobe from host
//   ioctl_addr     byte address (25 bit)
//   ioctl_dout     byte data
//   ioctl_wait     stall request to host (high during PAD and HOLD)
//   upload         one-cycle write strobe to the machine core
//   upload_index   index accompanying upload
//   upload_addr    write address
//   upload_data    write data
//   cpu_reset      active-high reset to CPU / machine core
//   cart_size      accepted image byte count, saturating at 16'hFFFF
//   load_done      high from DONE entry until the next session starts
//   overflow       sticky: a byte at or above PAD_LIMIT was offered
// ---------------------------------------------------------------------------
module cart_loader #(
    parameter logic [24:0] PAD_LIMIT   = 25'h8000,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [7:0]  CART_INDEX  = 8'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        upload,
    output logic [7:0]  upload_index,
    output logic [24:0] upload_addr,
    output logic [7:0]  upload_data,
    output logic        cpu_reset,
    output logic [15:0] cart_size,
    output logic        load_done,
    output logic        overflow
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PAD  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Last pad address and last hold count value.
    localparam logic [24:0] PAD_LAST  = PAD_LIMIT - 25'd1;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;

    logic        upload_r;
    logic [7:0]  upload_index_r;
    logic [24:0] upload_addr_r;
    logic [7:0]  upload_data_r;
    logic        ioctl_wait_r;
    logic        cpu_reset_r;
    logic [15:0] cart_size_r;
    logic        load_done_r;
    logic        overflow_r;
    logic [24:0] mark_r;
    logic [24:0] pad_ptr_r;
    logic [15:0] hold_cnt_r;

    logic        start_s;
    logic        accept_s;
    logic        drop_s;
    logic        pad_wr_s;
    logic        load_start_s;
    logic        pad_start_s;
    logic [24:0] addr_inc_s;
    logic [24:0] mark_nxt_s;

    // Wr strobes are only honoured in LOAD; in PAD/HOLD ioctl_wait is high
    // so any strobe there is a host violation and is simply not looked at.
    assign start_s      = ioctl_download && (ioctl_index == CART_INDEX);
    assign accept_s     = (state_r == ST_LOAD) && ioctl_wr && (ioctl_addr < PAD_LIMIT);
    assign drop_s       = (state_r == ST_LOAD) && ioctl_wr && (ioctl_addr >= PAD_LIMIT);
    assign pad_wr_s     = (state_r == ST_PAD) && (pad_ptr_r < PAD_LIMIT);
    assign load_start_s = (state_nxt_s == ST_LOAD) && (state_r != ST_LOAD);
    assign pad_start_s  = (state_r == ST_LOAD) && (state_nxt_s == ST_PAD);
    assign addr_inc_s   = ioctl_addr + 25'd1;

    // High-water mark including a byte accepted in this very cycle, so the
    // pad pointer is correct even if the last write coincides with LOAD exit.
    always_comb begin
        mark_nxt_s = mark_r;
        if (accept_s && (addr_inc_s > mark_r)) begin
            mark_nxt_s = addr_inc_s;
        end else begin
            mark_nxt_s = mark_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_LOAD;
                else         state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (!ioctl_download) state_nxt_s = ST_PAD;
                else                 state_nxt_s = ST_LOAD;
            end
            ST_PAD: begin
                // Covers both the final pad write and the full-image case
                // where the pointer already sits at PAD_LIMIT.
                if (pad_ptr_r >= PAD_LAST) state_nxt_s = ST_HOLD;
                else                       state_nxt_s = ST_PAD;
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) state_nxt_s = ST_DONE;
                else                         state_nxt_s = ST_HOLD;
            end
            ST_DONE: begin
                if (start_s) state_nxt_s = ST_LOAD;
                else         state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Upload port: image bytes take priority (only one source is ever live).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upload_r       <= 1'b0;
            upload_index_r <= 8'd0;
            upload_addr_r  <= 25'd0;
            upload_data_r  <= 8'd0;
        end else if (accept_s) begin
            upload_r       <= 1'b1;
            upload_index_r <= CART_INDEX;
            upload_addr_r  <= ioctl_addr;
            upload_data_r  <= ioctl_dout;
        end else if (pad_wr_s) begin
            upload_r       <= 1'b1;
            upload_index_r <= CART_INDEX;
            upload_addr_r  <= pad_ptr_r;
            upload_data_r  <= 8'hFF;
        end else begin
            upload_r       <= 1'b0;
        end
    end

    // Session bookkeeping: byte count, overflow flag, high-water mark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cart_size_r <= 16'd0;
            overflow_r  <= 1'b0;
            mark_r      <= 25'd0;
        end else if (load_start_s) begin
            cart_size_r <= 16'd0;
            overflow_r  <= 1'b0;
            mark_r      <= 25'd0;
        end else begin
            if (accept_s && (cart_size_r != 16'hFFFF)) cart_size_r <= cart_size_r + 16'd1;
            else                                       cart_size_r <= cart_size_r;
            if (drop_s) overflow_r <= 1'b1;
            else        overflow_r <= overflow_r;
            mark_r <= mark_nxt_s;
        end
    end

    // Pad pointer and hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad_ptr_r  <= 25'd0;
            hold_cnt_r <= 16'd0;
        end else begin
            if (pad_start_s)   pad_ptr_r <= mark_nxt_s;
            else if (pad_wr_s) pad_ptr_r <= pad_ptr_r + 25'd1;
            else               pad_ptr_r <= pad_ptr_r;
            if (state_r == ST_HOLD) hold_cnt_r <= hold_cnt_r + 16'd1;
            else                    hold_cnt_r <= 16'd0;
        end
    end

    // Status outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset_r  <= 1'b1;
            ioctl_wait_r <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            cpu_reset_r  <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_PAD) ||
                            (state_nxt_s == ST_HOLD);
            ioctl_wait_r <= (state_nxt_s == ST_PAD) || (state_nxt_s == ST_HOLD);
            load_done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign ioctl_wait   = ioctl_wait_r;
    assign upload       = upload_r;
    assign upload_index = upload_index_r;
    assign upload_addr  = upload_addr_r;
    assign upload_data  = upload_data_r;
    assign cpu_reset    = cpu_reset_r;
    assign cart_size    = cart_size_r;
    assign load_done    = load_done_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_cart_loader.sv
// ---------------------------------------------------------------------------
// tb_cart_loader
// Directed bench for cart_loader with a reduced cart window (PAD_LIMIT 64)
// and short hold (8 cycles). Inputs change 1 ns after a rising edge and the
// registered outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_cart_loader;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        upload;
    logic [7:0]  upload_index;
    logic [24:0] upload_addr;
    logic [7:0]  upload_data;
    logic        cpu_reset;
    logic [15:0] cart_size;
    logic        load_done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cart_loader #(
        .PAD_LIMIT  (25'h40),
        .HOLD_CYCLES(8),
        .CART_INDEX (8'd1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .upload        (upload),
        .upload_index  (upload_index),
        .upload_addr   (upload_addr),
        .upload_data   (upload_data),
        .cpu_reset     (cpu_reset),
        .cart_size     (cart_size),
        .load_done     (load_done),
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_upload"},  32'(upload),       32'(0));
        chk({tag, "_uindex"},  32'(upload_index), 32'(0));
        chk({tag, "_uaddr"},   32'(upload_addr),  32'(0));
        chk({tag, "_udata"},   32'(upload_data),  32'(0));
        chk({tag, "_wait"},    32'(ioctl_wait),   32'(0));
        chk({tag, "_cpurst"},  32'(cpu_reset),    32'(1));
        chk({tag, "_size"},    32'(cart_size),    32'(0));
        chk({tag, "_done"},    32'(load_done),    32'(0));
        chk({tag, "_ovf"},     32'(overflow),     32'(0));
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;

        // Reset state, then release: cpu_reset drops on the first edge.
        #12;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        step();
        chk("rel_cpurst", 32'(cpu_reset), 32'(0));

        // Foreign index: ignored entirely.
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'hAA;
        step();
        chk("idx0_upload", 32'(upload), 32'(0));
        ioctl_wr = 1'b0;
        step();
        chk("idx0_cpurst", 32'(cpu_reset),  32'(0));
        chk("idx0_wait",   32'(ioctl_wait), 32'(0));
        chk("idx0_upload2", 32'(upload),    32'(0));
        ioctl_download = 1'b0;
        step();

        // Session A: 8 bytes at 0..7, data 10..17, pad 8..63, hold, done.
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        step();
        chk("A_cpurst", 32'(cpu_reset), 32'(1));
        chk("A_done0",  32'(load_done), 32'(0));
        for (int i = 0; i < 8; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(8'h10 + i);
            step();
            chk("A_upload", 32'(upload),       32'(1));
            chk("A_uaddr",  32'(upload_addr),  32'(i));
            chk("A_udata",  32'(upload_data),  32'(8'h10 + i));
            chk("A_uindex", 32'(upload_index), 32'(1));
            ioctl_wr = 1'b0;
            step();
            chk("A_gap",      32'(upload),      32'(0));
            chk("A_gap_addr", 32'(upload_addr), 32'(i));
        end
        chk("A_size", 32'(cart_size), 32'(8));
        ioctl_download = 1'b0;
        step();
        chk("A_pad_wait",   32'(ioctl_wait), 32'(1));
        chk("A_pad_upload", 32'(upload),     32'(0));
        for (int a = 8; a < 64; a++) begin
            step();
            chk("A_pad_upload", 32'(upload),      32'(1));
            chk("A_pad_addr",   32'(upload_addr), 32'(a));
            chk("A_pad_data",   32'(upload_data), 32'(8'hFF));
        end
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'd5;
                ioctl_dout = 8'h77;
            end else begin
                ioctl_wr = 1'b0;
            end
            step();
            chk("A_hold_upload", 32'(upload),     32'(0));
            chk("A_hold_cpurst", 32'(cpu_reset),  32'(1));
            chk("A_hold_wait",   32'(ioctl_wait), 32'(1));
        end
        ioctl_wr = 1'b0;
        step();
        chk("A_done_cpurst", 32'(cpu_reset),  32'(0));
        chk("A_done",        32'(load_done),  32'(1));
        chk("A_done_wait",   32'(ioctl_wait), 32'(0));
        chk("A_done_size",   32'(cart_size),  32'(8));
        chk("A_done_ovf",    32'(overflow),   32'(0));
        chk("A_done_upload", 32'(upload),     32'(0));

        // Session B: out-of-range byte sets overflow; pad resumes at mark 4.
        ioctl_download = 1'b1;
        step();
        chk("B_done0",  32'(load_done), 32'(0));
        chk("B_cpurst", 32'(cpu_reset), 32'(1));
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h40;
        ioctl_dout = 8'h55;
        step();
        chk("B_drop_upload", 32'(upload),    32'(0));
        chk("B_drop_ovf",    32'(overflow),  32'(1));
        chk("B_drop_size",   32'(cart_size), 32'(0));
        ioctl_addr = 25'd3;
        ioctl_dout = 8'h33;
        step();
        chk("B_upload", 32'(upload),      32'(1));
        chk("B_uaddr",  32'(upload_addr), 32'(3));
        chk("B_udata",  32'(upload_data), 32'(8'h33));
        chk("B_size",   32'(cart_size),   32'(1));
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        chk("B_pad_wait", 32'(ioctl_wait), 32'(1));
        for (int a = 4; a < 64; a++) begin
            step();
            chk("B_pad_upload", 32'(upload),      32'(1));
            chk("B_pad_addr",   32'(upload_addr), 32'(a));
        end
        for (int k = 1; k < 8; k++) begin
            step();
            chk("B_hold_upload", 32'(upload), 32'(0));
        end
        step();
        chk("B_done",     32'(load_done), 32'(1));
        chk("B_done_ovf", 32'(overflow),  32'(1));

        // Session C: full 64-byte image, no pad, one-cycle PAD.
        ioctl_download = 1'b1;
        step();
        chk("C_ovf_clr",  32'(overflow),  32'(0));
        chk("C_size_clr", 32'(cart_size), 32'(0));
        for (int i = 0; i < 64; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'(i ^ 8'hA5);
            step();
            chk("C_upload", 32'(upload),      32'(1));
            chk("C_uaddr",  32'(upload_addr), 32'(i));
            chk("C_udata",  32'(upload_data), 32'((i ^ 8'hA5) & 8'hFF));
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        chk("C_pad_wait",   32'(ioctl_wait), 32'(1));
        chk("C_pad_upload", 32'(upload),     32'(0));
        step();
        chk("C_nopad_upload", 32'(upload),     32'(0));
        chk("C_hold_wait",    32'(ioctl_wait), 32'(1));
        for (int k = 1; k < 8; k++) begin
            step();
            chk("C_hold_cpurst", 32'(cpu_reset), 32'(1));
            chk("C_hold_upload", 32'(upload),    32'(0));
        end
        step();
        chk("C_done",     32'(load_done), 32'(1));
        chk("C_done_sz",  32'(cart_size), 32'(64));
        chk("C_done_ovf", 32'(overflow),  32'(0));

        // Session D: download re-asserted mid-PAD is deferred until DONE.
        ioctl_download = 1'b1;
        step();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'hC0;
        step();
        ioctl_addr = 25'd1;
        ioctl_dout = 8'hC1;
        step();
        chk("D_size", 32'(cart_size), 32'(2));
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        step();
        chk("D_pad_wait", 32'(ioctl_wait), 32'(1));
        for (int a = 2; a < 64; a++) begin
            if (a == 10) ioctl_download = 1'b1;
            step();
            chk("D_pad_upload", 32'(upload),      32'(1));
            chk("D_pad_addr",   32'(upload_addr), 32'(a));
            chk("D_pad_wait",   32'(ioctl_wait),  32'(1));
        end
        for (int k = 1; k < 8; k++) begin
            step();
            chk("D_hold_wait",   32'(ioctl_wait), 32'(1));
            chk("D_hold_cpurst", 32'(cpu_reset),  32'(1));
            chk("D_hold_done",   32'(load_done),  32'(0));
        end
        step();
        chk("D_done",        32'(load_done), 32'(1));
        chk("D_done_cpurst", 32'(cpu_reset), 32'(0));
        step();
        chk("D_reload_cpurst", 32'(cpu_reset),  32'(1));
        chk("D_reload_done",   32'(load_done),  32'(0));
        chk("D_reload_size",   32'(cart_size),  32'(0));
        chk("D_reload_wait",   32'(ioctl_wait), 32'(0));

        // Empty image: pad starts at 0; reset asserted at pad address 20.
        ioctl_download = 1'b0;
        step();
        chk("E_pad_wait", 32'(ioctl_wait), 32'(1));
        for (int a = 0; a <= 20; a++) begin
            step();
            chk("E_pad_addr", 32'(upload_addr), 32'(a));
        end
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        #1 reset_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            step();
            chk("E_post_upload", 32'(upload), 32'(0));
            if (n == 0) begin
                chk("E_post_cpurst", 32'(cpu_reset),  32'(0));
                chk("E_post_wait",   32'(ioctl_wait), 32'(0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
